pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enable, flush and bubble controls of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards in ID against EX, applies taken-branch flushes from EX, and freezes the front end while the data memory is busy.
- State and counters update on the rising CLK edge. Pipeline registers capture on the falling edge, so the combinational controls are settled half a cycle before capture.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : state encoding and ID/EX control-field widths
// Revision 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // Fields of the ID/EX register that IDEX_BUBBLE forces to zero
  localparam int ALUOP_W     = 2;
  localparam int ALUSRC_W    = 1;
  localparam int BRANCH_W    = 1;
  localparam int MEMREAD_W   = 1;
  localparam int MEMWRITE_W  = 1;
  localparam int REGWRITE_W  = 1;
  localparam int MEMTOREG_W  = 1;
  localparam int IDEX_CTRL_W = ALUOP_W + ALUSRC_W + BRANCH_W + MEMREAD_W
                             + MEMWRITE_W + REGWRITE_W + MEMTOREG_W;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : W-bit saturating event counter with synchronous clear
// Revision 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (CLR) begin
      cnt_q <= '0;
    end else if (INC && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign Q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall / flush / bubble sequencer for the 5-stage pipeline
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_MemRead,
  input  logic             EX_BRANCH_TAKEN,
  input  logic             MEM_BUSY,
  input  logic             CNT_CLR,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IFID_FLUSH,
  output logic             IDEX_WRITE,
  output logic             IDEX_BUBBLE,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] flush_rem_q, flush_rem_d;
  logic       ret_flush_q, ret_flush_d;
  logic       lu_hazard;
  logic       in_flush;

  assign lu_hazard = EX_MemRead && (EX_RD != '0) &&
                     ((ID_USES_RS1 && (EX_RD == ID_RS1)) ||
                      (ID_USES_RS2 && (EX_RD == ID_RS2)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      flush_rem_q <= 3'd0;
      ret_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      ret_flush_q <= ret_flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_rem_d = flush_rem_q;
    ret_flush_d = ret_flush_q;
    PC_WRITE    = 1'b1;
    IFID_WRITE  = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_WRITE  = 1'b1;
    IDEX_BUBBLE = 1'b0;

    // MEM_WAIT resolves to whichever mode it froze; the unused code 3 acts as RUN
    case (state_q)
      ST_FLUSH:    in_flush = 1'b1;
      ST_MEM_WAIT: in_flush = ret_flush_q;
      default:     in_flush = 1'b0;
    endcase

    if (RST) begin
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_BUBBLE = 1'b1;
      state_d     = ST_RUN;
      flush_rem_d = 3'd0;
      ret_flush_d = 1'b0;
    end else if (MEM_BUSY) begin
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
      IDEX_WRITE  = 1'b0;
      ret_flush_d = in_flush;
      state_d     = ST_MEM_WAIT;
    end else if (in_flush) begin
      IFID_FLUSH  = 1'b1;
      IDEX_BUBBLE = 1'b1;
      flush_rem_d = flush_rem_q - 3'd1;
      state_d     = (flush_rem_q <= 3'd1) ? ST_RUN : ST_FLUSH;
    end else begin
      state_d = ST_RUN;
      if (EX_BRANCH_TAKEN) begin
        IFID_FLUSH  = 1'b1;
        IDEX_BUBBLE = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          flush_rem_d = FLUSH_INIT;
          state_d     = ST_FLUSH;
        end
      end else if (lu_hazard) begin
        PC_WRITE    = 1'b0;
        IFID_WRITE  = 1'b0;
        IDEX_BUBBLE = 1'b1;
      end
    end
  end

  assign STATE = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CNT_CLR),
    .INC (~PC_WRITE),
    .Q   (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CNT_CLR),
    .INC (IFID_FLUSH),
    .Q   (FLUSH_CNT)
  );

endmodule

`default_nettype wire
